// File: rtl/universal_shift_register_burst.sv
// Universal shift register: direct hold/shift/load modes plus a burst engine
// that shifts or rotates N positions per Start request with Busy/Done handshake.
module universal_shift_register_burst #(
  parameter int unsigned           WIDTH       = 16,
  parameter int unsigned           CNT_W       = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [1:0]       Mode_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Serial_Left_In,
  input  logic             Serial_Right_In,
  input  logic             Start_In,
  input  logic             Dir_In,
  input  logic             Rotate_In,
  input  logic [CNT_W-1:0] Shift_Count_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Right_Out,
  output logic             Serial_Left_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_rot;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_rot_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // State and datapath registers; reset aborts any burst without a Done pulse.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_state <= S_IDLE;
      r_q     <= RESET_VALUE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_rot   <= w_rot_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, next-register and registered Busy/Done decode.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_rot_nxt   = r_rot;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start_In) begin
          w_cnt_nxt = Shift_Count_In;
          w_dir_nxt = Dir_In;
          w_rot_nxt = Rotate_In;
          if (Shift_Count_In == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_SHIFT;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          unique case (Mode_In)
            2'b00: w_q_nxt = r_q;
            2'b01: w_q_nxt = {Serial_Left_In, r_q[WIDTH-1:1]};
            2'b10: w_q_nxt = {r_q[WIDTH-2:0], Serial_Right_In};
            2'b11: w_q_nxt = Parallel_Data_In;
          endcase
        end
      end
      S_SHIFT: begin
        if (!r_dir)
          w_q_nxt = {(r_rot ? r_q[0] : Serial_Left_In), r_q[WIDTH-1:1]};
        else
          w_q_nxt = {r_q[WIDTH-2:0], (r_rot ? r_q[WIDTH-1] : Serial_Right_In)};
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Parallel_Data_Out = r_q;
  assign Serial_Right_Out  = r_q[0];
  assign Serial_Left_Out   = r_q[WIDTH-1];
  assign Busy_Out          = r_busy;
  assign Done_Out          = r_done;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Directed bench for universal_shift_register_burst (WIDTH = 16).
module tb_universal_shift_register_burst;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pdata;
  logic             sl_in;
  logic             sr_in;
  logic             start;
  logic             dir;
  logic             rot;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             sr_out;
  logic             sl_out;
  logic             busy;
  logic             done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  universal_shift_register_burst #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .RESET_VALUE('0)
  ) dut (
    .Clk_In           (clk),
    .Reset_In         (rst_n),
    .Mode_In          (mode),
    .Parallel_Data_In (pdata),
    .Serial_Left_In   (sl_in),
    .Serial_Right_In  (sr_in),
    .Start_In         (start),
    .Dir_In           (dir),
    .Rotate_In        (rot),
    .Shift_Count_In   (cnt),
    .Parallel_Data_Out(q),
    .Serial_Right_Out (sr_out),
    .Serial_Left_Out  (sl_out),
    .Busy_Out         (busy),
    .Done_Out         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] pdata;
    logic             sl;
    logic             sr;
    logic             start;
    logic             dir;
    logic             rot;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp_q;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed);
    check({name, ".q"}, 32'(q), 32'(eq));
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic idle_inputs();
    mode = 2'b00; start = 1'b0; sl_in = 1'b0; sr_in = 1'b0;
    dir = 1'b0; rot = 1'b0; cnt = '0; pdata = '0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    idle_inputs();
    mode = 2'b11; pdata = v;
    step();
    mode = 2'b00;
    check("load", 32'(q), 32'(v));
  endtask

  // Start a burst of n > 0 positions and check the full Busy/Done timeline.
  task automatic run_burst(input string name, input logic d, input logic r,
                           input int unsigned n, input logic fill,
                           input logic [WIDTH-1:0] exp_final);
    logic [WIDTH-1:0] q0;
    q0 = q;
    idle_inputs();
    start = 1'b1; dir = d; rot = r; cnt = CNT_W'(n);
    sl_in = fill; sr_in = fill;
    step();
    // Disturb ignored inputs while busy
    start = 1'b1; mode = 2'b11; pdata = 16'h5A5A; cnt = CNT_W'(1); dir = ~d; rot = ~r;
    check_state({name, ".e0"}, q0, 1'b1, 1'b0);
    for (int i = 1; i < int'(n); i++) begin
      step();
      check({name, ".busy"}, 32'(busy), 32'd1);
      check({name, ".done"}, 32'(done), 32'd0);
    end
    step();
    check_state({name, ".fin"}, exp_final, 1'b0, 1'b1);
    idle_inputs();
    step();
    check_state({name, ".post"}, exp_final, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    //               mode  pdata     sl  sr  st  dir rot cnt  exp_q     bsy dn
    tbl[0] = '{2'b11, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h8001, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'hC000, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h8000, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h8000, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h1234, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h091A, 1'b0, 1'b0};
    tbl[6] = '{2'b10, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h1235, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'hA5C3, 1'b0, 1'b0};
    // N = 0 burst with load requested: burst wins, Done next cycle, no Busy
    tbl[8] = '{2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 16'hA5C3, 1'b0, 1'b1};
    // DONE state ignores the load request
    tbl[9] = '{2'b11, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'hA5C3, 1'b0, 1'b0};

    step();
    step();
    check_state("reset_init", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_state("post_release", 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle
    do_load(16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_reset", 16'h0000, 1'b0, 1'b0);
    check("async_reset.sr_out", 32'(sr_out), 32'd0);
    check("async_reset.sl_out", 32'(sl_out), 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();

    // Table-driven direct modes and N = 0 corner
    for (int i = 0; i < 10; i++) begin
      mode = tbl[i].mode; pdata = tbl[i].pdata; sl_in = tbl[i].sl; sr_in = tbl[i].sr;
      start = tbl[i].start; dir = tbl[i].dir; rot = tbl[i].rot; cnt = tbl[i].cnt;
      step();
      check($sformatf("vec%0d.q", i), 32'(q), 32'(tbl[i].exp_q));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(tbl[i].exp_done));
      check($sformatf("vec%0d.sr_out", i), 32'(sr_out), 32'(tbl[i].exp_q[0]));
      check($sformatf("vec%0d.sl_out", i), 32'(sl_out), 32'(tbl[i].exp_q[WIDTH-1]));
    end
    idle_inputs();
    step();

    // Rotate right by 4 with intermediate values
    do_load(16'h1234);
    start = 1'b1; dir = 1'b0; rot = 1'b1; cnt = 5'd4;
    step();
    check_state("rotr4.e0", 16'h1234, 1'b1, 1'b0);
    mode = 2'b11; pdata = 16'hFFFF; cnt = 5'd1;
    step();
    check_state("rotr4.e1", 16'h091A, 1'b1, 1'b0);
    step();
    check_state("rotr4.e2", 16'h048D, 1'b1, 1'b0);
    step();
    check_state("rotr4.e3", 16'h8246, 1'b1, 1'b0);
    step();
    check_state("rotr4.e4", 16'h4123, 1'b0, 1'b1);
    step();
    check_state("rotr4.e5", 16'h4123, 1'b0, 1'b0);
    idle_inputs();
    step();
    check_state("rotr4.idle", 16'h4123, 1'b0, 1'b0);

    // Long shift left with fill 1, and rotate by full width
    do_load(16'h0000);
    run_burst("shl20", 1'b1, 1'b0, 20, 1'b1, 16'hFFFF);
    do_load(16'hA5C3);
    run_burst("rotl16", 1'b1, 1'b1, 16, 1'b0, 16'hA5C3);
    do_load(16'h8001);
    run_burst("shr3", 1'b0, 1'b0, 3, 1'b1, 16'hF000);

    // Reset during the third busy cycle of an N = 8 burst
    do_load(16'h00FF);
    start = 1'b1; dir = 1'b0; rot = 1'b1; cnt = 5'd8;
    step();
    start = 1'b0;
    step();
    step();
    check_state("rst_burst.pre", 16'hC03F, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_state("rst_burst.abort", 16'h0000, 1'b0, 1'b0);
    step();
    #2 rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      step();
      check_state($sformatf("rst_burst.quiet%0d", i), 16'h0000, 1'b0, 1'b0);
    end
    do_load(16'h1234);
    run_burst("after_rst", 1'b0, 1'b1, 4, 1'b0, 16'h4123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
